led_pattern_gen: RTL and testbench
==================================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter NCH, default 4, number of independent LED channels (1..16).
REQ-002 Parameter CNT_W, default 25, width of the per-channel half-period counter and of cfg_half.
REQ-003 Parameter BURST_W, default 8, width of the burst-length field.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 cfg_we  input  1  configuration write strobe, sampled on rising clk edges.
REQ-007 cfg_ch  input  max(1,clog2(NCH))  target channel of the write.
REQ-008 cfg_mode  input  2  0=OFF, 1=ON, 2=BLINK, 3=BURST.
REQ-009 cfg_half  input  CNT_W  half-period in clk cycles.
REQ-010 cfg_burst  input  BURST_W  number of on/off pulses for BURST.
REQ-011 led  output  NCH  registered LED drive, one bit per channel.
REQ-012 busy  output  NCH  registered; 1 while the channel is in RUN.
REQ-013 done  output  NCH  registered one-cycle pulse at BURST completion.
REQ-014 blink_cnt  output  16*NCH  rising-edge count per channel; exists only under LED_PATTERN_CNT_EN.

Function
REQ-015 Each channel SHALL hold its mode, half-period, remaining-toggle count, a CNT_W-bit cycle counter and state OFF, ON or RUN.
REQ-016 A write with cfg_we=1 and cfg_ch<NCH SHALL update only that channel at that edge; cfg_ch>=NCH SHALL be ignored.
REQ-017 Mode OFF: state OFF, led=0 from the next edge; mode ON: state ON, led=1 from the next edge.
REQ-018 Mode BLINK or BURST: state RUN, counter cleared, led forced 0 at the write edge.
REQ-019 cfg_half=0 SHALL be stored as 1.
REQ-020 In RUN the counter SHALL increment every clk; when it equals half-1 it SHALL clear and led SHALL toggle on the same edge, giving a period of 2*half cycles.
REQ-021 BLINK SHALL toggle indefinitely.
REQ-022 BURST SHALL load 2*cfg_burst toggles; at the edge of the final toggle (led returns 0) the channel SHALL enter OFF, busy SHALL fall and done SHALL pulse high for exactly one cycle.
REQ-023 BURST with cfg_burst=0 SHALL enter OFF directly and pulse done on the cycle after the write.
REQ-024 A write to a channel in RUN SHALL abort it with no done pulse and apply the new mode per REQ-017/018.
REQ-025 A write coinciding with a channel's toggle or burst-completion edge SHALL take priority; the toggle and done for that edge SHALL be suppressed.
REQ-026 Channels SHALL be fully independent; simultaneous completions on several channels SHALL each pulse done.

Reset
REQ-027 While rst=1: all channels OFF; led, busy and done all 0; counters 0; blink_cnt 0; half-periods 1; burst counts 0.
REQ-028 Reset SHALL take effect immediately without a clock edge, including mid-burst, and SHALL produce no done pulse.

Configuration
REQ-029 With LED_PATTERN_CNT_EN defined, each channel SHALL increment its 16-bit blink_cnt on every led 0->1 transition, wrap 65535->0, and clear on any write to that channel.
REQ-030 Without LED_PATTERN_CNT_EN, port blink_cnt and its counters SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Reset release, no writes for 100 cycles -> led=0, busy=0, done=0 on all channels.
REQ-032 Write ch0 BLINK half=5 -> led[0] rises 5 cycles after the write edge, period 10 cycles, busy[0]=1 continuously.
REQ-033 Write ch1 BURST half=3 burst=2 -> four toggles at write+3/6/9/12; done[1] is high for one cycle at write+12; led[1]=0 and busy[1]=0 afterwards.
REQ-034 Write ch2 BURST half=4 burst=3; rewrite ch2 ON at write+10 -> no done pulse; led[2]=1 from the next edge; busy[2]=0.
REQ-035 Assert rst mid-burst on ch3 at a non-clock-edge time -> led[3], busy[3] and done[3] are 0 immediately; no done pulse after release.
REQ-036 With LED_PATTERN_CNT_EN, ch0 BLINK half=1 for 131074 cycles -> blink_cnt[0] wraps and reads 1; write cfg_ch=NCH -> no channel changes.

Source files
------------

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: NCH independent LED channels, each OFF, steady ON, free-running
// BLINK, or a counted BURST of on/off pulses with a one-cycle done pulse.
// Ports:
//   clk, rst (async active-high)
//   cfg_we/cfg_ch/cfg_mode/cfg_half/cfg_burst : per-channel configuration write
//   led, busy, done : registered per-channel outputs
//   blink_cnt : 16-bit rising-edge counter per channel, only with LED_PATTERN_CNT_EN
// Optional feature macro: LED_PATTERN_CNT_EN (adds blink_cnt and its counters).
module led_pattern_gen #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 25,
  parameter int BURST_W = 8,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [1:0]         cfg_mode,
  input  logic [CNT_W-1:0]   cfg_half,
  input  logic [BURST_W-1:0] cfg_burst,
  output logic [NCH-1:0]     led,
  output logic [NCH-1:0]     busy,
`ifdef LED_PATTERN_CNT_EN
  output logic [16*NCH-1:0]  blink_cnt,
`endif
  output logic [NCH-1:0]     done
);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  typedef enum logic [1:0] {ST_OFF, ST_ON, ST_RUN} st_e;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    st_e                st_q, st_d;
    logic [1:0]         mode_q, mode_d;
    logic [CNT_W-1:0]   half_q, half_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BURST_W:0]   rem_q, rem_d;    // remaining toggles, up to 2*cfg_burst
    logic               led_q, led_d;
    logic               done_q, done_d;
    logic               wr;

    // Out-of-range channel numbers never match any g, so they are ignored.
    assign wr = cfg_we && (int'(cfg_ch) == g);

    always_comb begin
      st_d   = st_q;
      mode_d = mode_q;
      half_d = half_q;
      cnt_d  = cnt_q;
      rem_d  = rem_q;
      led_d  = led_q;
      done_d = 1'b0;
      if (wr) begin
        // A write always wins over a same-edge toggle or completion.
        mode_d = cfg_mode;
        half_d = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
        cnt_d  = '0;
        rem_d  = {cfg_burst, 1'b0};
        led_d  = 1'b0;
        case (cfg_mode)
          MODE_OFF:   st_d = ST_OFF;
          MODE_ON: begin
            st_d  = ST_ON;
            led_d = 1'b1;
          end
          MODE_BLINK: st_d = ST_RUN;
          MODE_BURST: begin
            if (cfg_burst == '0) begin
              st_d   = ST_OFF;
              done_d = 1'b1;
            end else begin
              st_d = ST_RUN;
            end
          end
        endcase
      end else if (st_q == ST_RUN) begin
        if (cnt_q == half_q - 1'b1) begin
          cnt_d = '0;
          led_d = ~led_q;
          if (mode_q == MODE_BURST) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == (BURST_W+1)'(1)) begin
              st_d   = ST_OFF;
              led_d  = 1'b0;
              done_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q   <= ST_OFF;
        mode_q <= MODE_OFF;
        half_q <= CNT_W'(1);
        cnt_q  <= '0;
        rem_q  <= '0;
        led_q  <= 1'b0;
        done_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        mode_q <= mode_d;
        half_q <= half_d;
        cnt_q  <= cnt_d;
        rem_q  <= rem_d;
        led_q  <= led_d;
        done_q <= done_d;
      end
    end

    assign led[g]  = led_q;
    assign busy[g] = (st_q == ST_RUN);
    assign done[g] = done_q;

`ifdef LED_PATTERN_CNT_EN
    logic [15:0] bc_q, bc_d;

    // Counts 0->1 transitions of the registered LED; wraps naturally at 16 bits.
    always_comb begin
      bc_d = bc_q;
      if (wr)
        bc_d = '0;
      else if (led_d && !led_q)
        bc_d = bc_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) bc_q <= '0;
      else     bc_q <= bc_d;
    end

    assign blink_cnt[16*g +: 16] = bc_q;
`endif
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
module tb_led_pattern_gen;
  localparam int NCH     = 5;
  localparam int CNT_W   = 25;
  localparam int BURST_W = 8;
  localparam int CH_W    = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_we = 1'b0;
  logic [CH_W-1:0]    cfg_ch = '0;
  logic [1:0]         cfg_mode = '0;
  logic [CNT_W-1:0]   cfg_half = '0;
  logic [BURST_W-1:0] cfg_burst = '0;
  logic [NCH-1:0]     led, busy, done;
`ifdef LED_PATTERN_CNT_EN
  logic [16*NCH-1:0]  blink_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int   cyc;
    int   ch;
    int   sid;
    int   k;
    logic l;
    logic b;
    logic d;
  } exp_t;
  exp_t sb[$];

  led_pattern_gen #(.NCH(NCH), .CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_half  (cfg_half),
    .cfg_burst (cfg_burst),
    .led       (led),
    .busy      (busy),
`ifdef LED_PATTERN_CNT_EN
    .blink_cnt (blink_cnt),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input int sid, input int ch, input int base, input int k,
                      input logic l, input logic b, input logic d);
    exp_t e;
    e.cyc = base + k; e.ch = ch; e.sid = sid; e.k = k;
    e.l = l; e.b = b; e.d = d;
    sb.push_back(e);
  endtask

  // Blink with half-period h: led is 0 for k in [0,h), 1 for [h,2h), ...
  task automatic push_blink(input int sid, input int ch, input int base, input int h,
                            input int k0, input int k1);
    for (int k = k0; k <= k1; k++)
      push(sid, ch, base, k, ((k / h) % 2) == 1, 1'b1, 1'b0);
  endtask

  // Burst of b pulses: running until k = 2*b*h, done exactly at that k.
  task automatic push_burst(input int sid, input int ch, input int base, input int h,
                            input int b, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      if (k < 2 * b * h)       push(sid, ch, base, k, ((k / h) % 2) == 1, 1'b1, 1'b0);
      else if (k == 2 * b * h) push(sid, ch, base, k, 1'b0, 1'b0, 1'b1);
      else                     push(sid, ch, base, k, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic push_const(input int sid, input int ch, input int base, input int k0,
                            input int k1, input logic l, input logic b, input logic d);
    for (int k = k0; k <= k1; k++) push(sid, ch, base, k, l, b, d);
  endtask

  // Returns the cycle index of the edge at which the write is sampled.
  task automatic do_write(input int ch, input logic [1:0] m, input int h, input int b,
                          output int w);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_mode  = m;
    cfg_half  = CNT_W'(h);
    cfg_burst = BURST_W'(b);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    w = cyc;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Scoreboard monitor: compare every expectation due in this cycle.
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        chk($sformatf("s%0d_c%0d_k%0d_led",  sb[i].sid, sb[i].ch, sb[i].k),
            32'(led[sb[i].ch]),  32'(sb[i].l));
        chk($sformatf("s%0d_c%0d_k%0d_busy", sb[i].sid, sb[i].ch, sb[i].k),
            32'(busy[sb[i].ch]), 32'(sb[i].b));
        chk($sformatf("s%0d_c%0d_k%0d_done", sb[i].sid, sb[i].ch, sb[i].k),
            32'(done[sb[i].ch]), 32'(sb[i].d));
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w2, base;

    // Reset state
    #12;
    chk("rst_led",  32'(led),  32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Idle for 100 cycles after release
    base = cyc;
    for (int c = 0; c < NCH; c++) push_const(1, c, base, 1, 100, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // BLINK half=5 on ch0, then abort with OFF (no done)
    do_write(0, 2'd2, 5, 0, w);
    push_blink(2, 0, w, 5, 0, 40);
    wait_drain();
    do_write(0, 2'd0, 5, 0, w);
    push_const(3, 0, w, 0, 5, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // BURST half=3 burst=2 on ch1
    do_write(1, 2'd3, 3, 2, w);
    push_burst(4, 1, w, 3, 2, 0, 20);
    wait_drain();

    // BURST on ch2 overwritten by ON at write+10
    do_write(2, 2'd3, 4, 3, w);
    push_burst(5, 2, w, 4, 3, 0, 9);
    repeat (9) @(posedge clk);
    do_write(2, 2'd1, 4, 3, w2);
    push_const(6, 2, w2, 0, 5, 1'b1, 1'b0, 1'b0);
    wait_drain();
    do_write(2, 2'd0, 1, 0, w);

    // Rewrite coinciding with a toggle edge: toggle suppressed
    do_write(3, 2'd2, 4, 0, w);
    push_blink(7, 3, w, 4, 0, 3);
    repeat (3) @(posedge clk);
    do_write(3, 2'd2, 2, 0, w2);
    push_blink(8, 3, w2, 2, 0, 9);
    wait_drain();
    do_write(3, 2'd0, 1, 0, w);

    // Rewrite coinciding with burst completion: done suppressed
    do_write(4, 2'd3, 2, 1, w);
    push_burst(9, 4, w, 2, 1, 0, 3);
    repeat (3) @(posedge clk);
    do_write(4, 2'd0, 1, 0, w2);
    push_const(10, 4, w2, 0, 5, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // half=0 behaves as half=1
    do_write(4, 2'd2, 0, 0, w);
    push_blink(11, 4, w, 1, 0, 9);
    wait_drain();
    do_write(4, 2'd0, 1, 0, w);

    // BURST with burst=0: straight to OFF with a done pulse
    do_write(1, 2'd3, 3, 0, w);
    push_burst(12, 1, w, 3, 0, 0, 4);
    wait_drain();

    // Simultaneous completions on ch0 and ch1
    do_write(0, 2'd3, 3, 2, w);
    push_burst(13, 0, w, 3, 2, 0, 15);
    @(posedge clk);
    do_write(1, 2'd3, 5, 1, w2);
    push_burst(14, 1, w2, 5, 1, 0, 13);
    wait_drain();

    // Out-of-range channel writes are ignored; running ch0 unaffected
    do_write(0, 2'd2, 3, 0, w);
    push_blink(15, 0, w, 3, 0, 24);
    do_write(5, 2'd1, 1, 0, w2);
    do_write(7, 2'd1, 1, 0, w2);
    for (int c = 1; c < NCH; c++) push_const(16, c, w2, 0, 5, 1'b0, 1'b0, 1'b0);
    wait_drain();
    do_write(0, 2'd0, 1, 0, w);

    // Async reset mid-burst on ch3
    do_write(3, 2'd3, 3, 4, w);
    push_burst(17, 3, w, 3, 4, 0, 2);
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_led3", 32'(led[3]), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_led3",  32'(led[3]),  32'd0);
    chk("arst_busy3", 32'(busy[3]), 32'd0);
    chk("arst_done3", 32'(done[3]), 32'd0);
    chk("arst_led",   32'(led),     32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base = cyc;
    push_const(18, 3, base, 1, 30, 1'b0, 1'b0, 1'b0);
    wait_drain();

`ifdef LED_PATTERN_CNT_EN
    // Rising-edge counter: half=1 gives a rise at every odd k
    do_write(0, 2'd2, 1, 0, w);
    repeat (20) @(negedge clk);
    chk("bc_count", 32'(blink_cnt[15:0]), 32'((cyc - w + 1) / 2));
    do_write(0, 2'd0, 1, 0, w);
    @(negedge clk);
    chk("bc_clear", 32'(blink_cnt[15:0]), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
